// File: rtl/lapido_pkg.sv
// Shared Lapido core definitions: opcode constants, ext-op encoding, instruction field positions.
package lapido_pkg;

  localparam int unsigned INSTR_BITS = 32;
  localparam int unsigned OPC_W      = 6;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned EXT_W      = 2;
  localparam int unsigned STALL_W    = 16;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LUI  = 6'h0F;

  localparam logic [EXT_W-1:0] EXT_SIGN  = 2'b00;
  localparam logic [EXT_W-1:0] EXT_ZERO  = 2'b01;
  localparam logic [EXT_W-1:0] EXT_UPPER = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  // Immediate extension mode selected by the opcode.
  function automatic logic [EXT_W-1:0] ext_op_decode(input logic [OPC_W-1:0] op);
    logic [EXT_W-1:0] ext;
    ext = EXT_SIGN;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: ext = EXT_ZERO;
      OP_LUI:                   ext = EXT_UPPER;
      default:                  ext = EXT_SIGN;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/if_id_skid.sv
// Generic two-entry valid/ready skid buffer with flush; head entry M, overflow entry S.
module if_id_skid
  import lapido_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              rdy_q;
  logic              vld_q;
  logic              accept;
  logic              pop;

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = m_q;

  // State register plus entry storage; invalid entries are held at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      rdy_q   <= (state_d != ST_FULL);
      vld_q   <= (state_d != ST_EMPTY);
    end
  end

  // Next-state and entry update; flush overrides any accept in the same cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    accept  = in_valid & rdy_q;
    pop     = vld_q & out_ready;

    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            m_d     = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            m_d = in_data;
          end else if (accept) begin
            s_d     = in_data;
            state_d = ST_FULL;
          end else if (pop) begin
            m_d     = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            m_d     = s_q;
            s_d     = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_d     = '0;
          s_d     = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Lapido fetch-to-decode pipeline register: skid buffer, field slicing and ext-op decode.
// Optional stall counter enabled by defining IF_ID_STALL_COUNT_EN.
module if_id_stage
  import lapido_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic [IMM_W-1:0]   out_imm,
  output logic [EXT_W-1:0]   out_ext_op
`ifdef IF_ID_STALL_COUNT_EN
  ,
  output logic [STALL_W-1:0] stall_count
`endif
);

  localparam int unsigned DATA_W = PC_W + INSTR_W;

  logic [DATA_W-1:0]  head_data;
  logic [INSTR_W-1:0] head_instr;

  if_id_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_pc, in_instr}),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_data)
  );

  // Head entry is zeroed by the buffer whenever it is invalid, so slices read zero too.
  assign head_instr = head_data[INSTR_W-1:0];
  assign out_pc     = head_data[DATA_W-1:INSTR_W];
  assign out_opcode = head_instr[OPC_MSB:OPC_LSB];
  assign out_rs     = head_instr[RS_MSB:RS_LSB];
  assign out_rt     = head_instr[RT_MSB:RT_LSB];
  assign out_rd     = head_instr[RD_MSB:RD_LSB];
  assign out_imm    = head_instr[IMM_MSB:IMM_LSB];
  assign out_ext_op = out_valid ? ext_op_decode(out_opcode) : EXT_SIGN;

`ifdef IF_ID_STALL_COUNT_EN
  // Saturating count of cycles where decode holds off a valid head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {STALL_W{1'b1}})) begin
      stall_count <= stall_count + STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (stall counter checked when IF_ID_STALL_COUNT_EN is defined).
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [15:0] out_imm;
  logic [1:0]  out_ext_op;
`ifdef IF_ID_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int n_checks;
  int n_errors;

  if_id_stage #(
    .PC_W   (32),
    .INSTR_W(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .out_ext_op (out_ext_op)
`ifdef IF_ID_STALL_COUNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  localparam logic [31:0] I_ADDI = 32'h2008FFF0;
  localparam logic [31:0] I_ORI  = 32'h3508F00F;
  localparam logic [31:0] I_LUI  = 32'h3C081234;
  localparam logic [31:0] I_A    = 32'h31000001; // ANDI imm 1
  localparam logic [31:0] I_B    = 32'h39000002; // XORI imm 2
  localparam logic [31:0] I_C    = 32'h3C000003; // LUI imm 3

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    chk("rst_imm", 32'(out_imm), 32'd0);
    chk("rst_ext", 32'(out_ext_op), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
`ifdef IF_ID_STALL_COUNT_EN
    chk("rst_stall", 32'(stall_count), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single ADDI: visible one cycle after accept.
    drive(1'b1, 32'h0, I_ADDI);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_opcode", 32'(out_opcode), 32'h08);
    chk("addi_rs", 32'(out_rs), 32'd0);
    chk("addi_rt", 32'(out_rt), 32'd8);
    chk("addi_rd", 32'(out_rd), 32'h1F);
    chk("addi_imm", 32'(out_imm), 32'hFFF0);
    chk("addi_ext", 32'(out_ext_op), 32'd0);
    chk("addi_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("addi_popped", 32'(out_valid), 32'd0);

    // Back-to-back ORI then LUI with decode always ready.
    drive(1'b1, 32'h4, I_ORI);
    tick();
    chk("ori_valid", 32'(out_valid), 32'd1);
    chk("ori_imm", 32'(out_imm), 32'hF00F);
    chk("ori_ext", 32'(out_ext_op), 32'd1);
    chk("ori_pc", out_pc, 32'h4);
    drive(1'b1, 32'h8, I_LUI);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("lui_valid", 32'(out_valid), 32'd1);
    chk("lui_opcode", 32'(out_opcode), 32'h0F);
    chk("lui_imm", 32'(out_imm), 32'h1234);
    chk("lui_ext", 32'(out_ext_op), 32'd2);
    chk("lui_pc", out_pc, 32'h8);
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure: A and B accepted, C waits until A pops.
    out_ready = 1'b0;
    drive(1'b1, 32'h10, I_A);
    tick();
    chk("bp_a_in_ready", 32'(in_ready), 32'd1);
    chk("bp_a_imm", 32'(out_imm), 32'h0001);
    drive(1'b1, 32'h14, I_B);
    tick();
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_imm", 32'(out_imm), 32'h0001);
    drive(1'b1, 32'h18, I_C);
    tick();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_stable_pc", out_pc, 32'h10);
    chk("bp_stable_ext", 32'(out_ext_op), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_head", 32'(out_imm), 32'h0002);
    chk("bp_b_pc", out_pc, 32'h14);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_c_head", 32'(out_imm), 32'h0003);
    chk("bp_c_ext", 32'(out_ext_op), 32'd2);
    chk("bp_c_pc", out_pc, 32'h18);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush while FULL with a concurrent input offer.
    out_ready = 1'b0;
    drive(1'b1, 32'h20, I_A);
    tick();
    drive(1'b1, 32'h24, I_B);
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h28, I_C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_full_valid", 32'(out_valid), 32'd0);
    chk("fl_full_ready", 32'(in_ready), 32'd1);
    chk("fl_full_imm", 32'(out_imm), 32'd0);
    tick();
    chk("fl_full_no_ghost", 32'(out_valid), 32'd0);

    // Flush in ONE with an acceptable input: the input is dropped.
    drive(1'b1, 32'h30, I_A);
    tick();
    drive(1'b1, 32'h34, I_B);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_one_valid", 32'(out_valid), 32'd0);
    tick();
    chk("fl_one_no_ghost", 32'(out_valid), 32'd0);
    chk("fl_one_pc", out_pc, 32'd0);

    // Asynchronous reset while FULL.
    drive(1'b1, 32'h40, I_A);
    tick();
    drive(1'b1, 32'h44, I_B);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_full_valid", 32'(out_valid), 32'd1);
    chk("ar_full_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    chk("ar_imm", 32'(out_imm), 32'd0);
    chk("ar_pc", out_pc, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_after_valid", 32'(out_valid), 32'd0);

    // Stall count: five stalled cycles, then a flush with a same-cycle pop.
    drive(1'b1, 32'h50, I_A);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("sc_valid", 32'(out_valid), 32'd1);
`ifdef IF_ID_STALL_COUNT_EN
    chk("sc_five", 32'(stall_count), 32'd5);
`endif
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    chk("sc_flushed", 32'(out_valid), 32'd0);
    tick();
`ifdef IF_ID_STALL_COUNT_EN
    chk("sc_kept", 32'(stall_count), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
